// File: rtl/ctr_readback.sv
// Snapshot a running counter and return it LSB-first over an 8-bit bus.
// DataOut updates one clock after RdStrobe; no backpressure, every strobe returns one byte.
module ctr_readback #(
    parameter int WIDTH = 16
) (
    input  logic                   MasterClock,
    input  logic                   ResetL,
    input  logic [WIDTH-1:0]       CountIn,
    input  logic                   LatchCmd,
    input  logic                   RdStrobe,
    input  logic                   CtrLoad,
    output logic [7:0]             DataOut,
    output logic                   Held,
    output logic [((WIDTH/8) > 1 ? $clog2(WIDTH/8) : 1)-1:0] ByteIdx
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic {LIVE = 1'b0, HELD = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [7:0]       data_q, data_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             held_q, held_d;
    logic [7:0]       snap_byte;

    always_comb begin
        snap_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IDXW'(i)) begin
                snap_byte = snap_q[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        data_d  = data_q;
        idx_d   = idx_q;

        if (CtrLoad) begin
            // A counter load invalidates any in-flight sequence; a coincident read sees the live value.
            if (RdStrobe) begin
                data_d = CountIn[7:0];
            end
            idx_d   = '0;
            state_d = LIVE;
        end else begin
            unique case (state_q)
                LIVE: begin
                    if (RdStrobe) begin
                        data_d = CountIn[7:0];
                        if (NBYTES > 1) begin
                            snap_d  = CountIn;
                            idx_d   = IDXW'(1);
                            state_d = HELD;
                        end
                    end else if (LatchCmd) begin
                        snap_d  = CountIn;
                        idx_d   = '0;
                        state_d = HELD;
                    end
                end
                HELD: begin
                    if (RdStrobe) begin
                        data_d = snap_byte;
                        if (idx_q == IDXW'(NBYTES - 1)) begin
                            idx_d   = '0;
                            state_d = LIVE;
                        end else begin
                            idx_d = idx_q + IDXW'(1);
                        end
                    end
                end
                default: state_d = LIVE;
            endcase
        end

        held_d = (state_d == HELD);
    end

    always_ff @(posedge MasterClock) begin
        if (!ResetL) begin
            state_q <= LIVE;
            snap_q  <= '0;
            data_q  <= 8'h00;
            idx_q   <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            held_q  <= held_d;
        end
    end

    assign DataOut = data_q;
    assign Held    = held_q;
    assign ByteIdx = idx_q;

endmodule

// File: tb/tb_ctr_readback.sv
// Scoreboard bench for ctr_readback at WIDTH=16 and WIDTH=32.
module tb_ctr_readback;

    logic        clk = 1'b0;
    logic        rst_l;

    logic [15:0] cnt16;
    logic        latch16, rd16, load16;
    logic [7:0]  dout16;
    logic        held16;
    logic [0:0]  idx16;

    logic [31:0] cnt32;
    logic        latch32, rd32, load32;
    logic [7:0]  dout32;
    logic        held32;
    logic [1:0]  idx32;

    logic [7:0]  exp_q16[$];
    logic [7:0]  exp_q32[$];
    logic [7:0]  exp_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ctr_readback #(.WIDTH(16)) dut16 (
        .MasterClock(clk), .ResetL(rst_l), .CountIn(cnt16), .LatchCmd(latch16),
        .RdStrobe(rd16), .CtrLoad(load16), .DataOut(dout16), .Held(held16), .ByteIdx(idx16)
    );

    ctr_readback #(.WIDTH(32)) dut32 (
        .MasterClock(clk), .ResetL(rst_l), .CountIn(cnt32), .LatchCmd(latch32),
        .RdStrobe(rd32), .CtrLoad(load32), .DataOut(dout32), .Held(held32), .ByteIdx(idx32)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_l = 1'b0;
        cnt16 = 16'hA55A; rd16 = 1'b1; latch16 = 1'b1; load16 = 1'b0;
        cnt32 = 32'hA55A_A55A; rd32 = 1'b1; latch32 = 1'b1; load32 = 1'b0;
        tick; tick;
        n_cmp++; if (dout16 !== 8'h00) begin n_err++; $display("FAIL reset_dout16: got %h want 00", dout16); end
        n_cmp++; if (held16 !== 1'b0)  begin n_err++; $display("FAIL reset_held16: got %b want 0", held16); end
        n_cmp++; if (idx16 !== 1'b0)   begin n_err++; $display("FAIL reset_idx16: got %0d want 0", idx16); end
        n_cmp++; if (dout32 !== 8'h00) begin n_err++; $display("FAIL reset_dout32: got %h want 00", dout32); end
        n_cmp++; if (held32 !== 1'b0)  begin n_err++; $display("FAIL reset_held32: got %b want 0", held32); end
        rst_l = 1'b1; rd16 = 1'b0; latch16 = 1'b0; rd32 = 1'b0; latch32 = 1'b0;
        cnt16 = 16'h1111; cnt32 = 32'h2222_2222;
        tick; tick;
        n_cmp++; if (dout16 !== 8'h00 || held16 !== 1'b0 || idx16 !== 1'b0) begin
            n_err++; $display("FAIL idle16: dout=%h held=%b idx=%0d want 00/0/0", dout16, held16, idx16);
        end
        n_cmp++; if (dout32 !== 8'h00 || held32 !== 1'b0 || idx32 !== 2'd0) begin
            n_err++; $display("FAIL idle32: dout=%h held=%b idx=%0d want 00/0/0", dout32, held32, idx32);
        end
    endtask

    task automatic test_auto_latch;
        cnt16 = 16'h12FF; rd16 = 1'b1; exp_q16.push_back(8'hFF);
        tick;
        rd16 = 1'b0; cnt16 = 16'h1300;
        exp_b = exp_q16.pop_front();
        n_cmp++; if (dout16 !== exp_b) begin n_err++; $display("FAIL auto_b0: got %h want %h", dout16, exp_b); end
        n_cmp++; if (held16 !== 1'b1 || idx16 !== 1'b1) begin
            n_err++; $display("FAIL auto_state0: held=%b idx=%0d want 1/1", held16, idx16);
        end
        rd16 = 1'b1; exp_q16.push_back(8'h12);
        tick;
        rd16 = 1'b0;
        exp_b = exp_q16.pop_front();
        n_cmp++; if (dout16 !== exp_b) begin n_err++; $display("FAIL auto_b1: got %h want %h", dout16, exp_b); end
        n_cmp++; if (held16 !== 1'b0 || idx16 !== 1'b0) begin
            n_err++; $display("FAIL auto_state1: held=%b idx=%0d want 0/0", held16, idx16);
        end
    endtask

    task automatic test_latch32;
        logic [31:0] val;
        val = 32'hDEADBEEF;
        cnt32 = val; latch32 = 1'b1;
        tick;
        latch32 = 1'b0;
        n_cmp++; if (held32 !== 1'b1 || idx32 !== 2'd0 || dout32 !== 8'h00) begin
            n_err++; $display("FAIL latch32: held=%b idx=%0d dout=%h want 1/0/00", held32, idx32, dout32);
        end
        for (int i = 0; i < 4; i++) begin
            cnt32 = $urandom;
            rd32 = 1'b1;
            exp_q32.push_back(val[i*8 +: 8]);
            tick;
            rd32 = 1'b0;
            exp_b = exp_q32.pop_front();
            n_cmp++; if (dout32 !== exp_b) begin n_err++; $display("FAIL latch32_b%0d: got %h want %h", i, dout32, exp_b); end
            n_cmp++; if (held32 !== (i < 3) || idx32 !== 2'((i + 1) % 4)) begin
                n_err++; $display("FAIL latch32_st%0d: held=%b idx=%0d want %b/%0d", i, held32, idx32, (i < 3), (i + 1) % 4);
            end
        end
    endtask

    task automatic test_latch_while_held;
        cnt16 = 16'h0001; latch16 = 1'b1;
        tick;
        cnt16 = 16'h0002;
        tick;
        latch16 = 1'b0;
        n_cmp++; if (held16 !== 1'b1 || idx16 !== 1'b0) begin
            n_err++; $display("FAIL held_latch: held=%b idx=%0d want 1/0", held16, idx16);
        end
        exp_q16.push_back(8'h01);
        exp_q16.push_back(8'h00);
        for (int i = 0; i < 2; i++) begin
            cnt16 = 16'(16'h5A00 + i); rd16 = 1'b1;
            tick;
            rd16 = 1'b0;
            if (exp_q16.size() == 0) begin
                n_cmp++; n_err++; $display("FAIL held_read%0d: scoreboard empty", i);
            end else begin
                exp_b = exp_q16.pop_front();
                n_cmp++; if (dout16 !== exp_b) begin n_err++; $display("FAIL held_read%0d: got %h want %h", i, dout16, exp_b); end
            end
        end
        n_cmp++; if (held16 !== 1'b0) begin n_err++; $display("FAIL held_end: held=%b want 0", held16); end
    endtask

    task automatic test_back_to_back;
        cnt16 = 16'hBEEF; latch16 = 1'b1; rd16 = 1'b1; exp_q16.push_back(8'hEF);
        tick;
        cnt16 = 16'h4444; exp_q16.push_back(8'hBE);
        exp_b = exp_q16.pop_front();
        n_cmp++; if (dout16 !== exp_b || idx16 !== 1'b1 || held16 !== 1'b1) begin
            n_err++; $display("FAIL both_b0: dout=%h idx=%0d held=%b want %h/1/1", dout16, idx16, held16, exp_b);
        end
        tick;
        latch16 = 1'b0; rd16 = 1'b0;
        exp_b = exp_q16.pop_front();
        n_cmp++; if (dout16 !== exp_b || held16 !== 1'b0 || idx16 !== 1'b0) begin
            n_err++; $display("FAIL both_b1: dout=%h held=%b idx=%0d want %h/0/0", dout16, held16, idx16, exp_b);
        end
        tick;
        n_cmp++; if (dout16 !== 8'hBE) begin n_err++; $display("FAIL dout_hold: got %h want be", dout16); end
    endtask

    task automatic test_ctr_load;
        cnt16 = 16'h3456; rd16 = 1'b1; exp_q16.push_back(8'h56);
        tick;
        exp_b = exp_q16.pop_front();
        n_cmp++; if (dout16 !== exp_b || idx16 !== 1'b1) begin
            n_err++; $display("FAIL load_pre: dout=%h idx=%0d want %h/1", dout16, idx16, exp_b);
        end
        cnt16 = 16'h0777; load16 = 1'b1; latch16 = 1'b1; exp_q16.push_back(8'h77);
        tick;
        load16 = 1'b0; latch16 = 1'b0;
        exp_b = exp_q16.pop_front();
        n_cmp++; if (dout16 !== exp_b || held16 !== 1'b0 || idx16 !== 1'b0) begin
            n_err++; $display("FAIL load_rd: dout=%h held=%b idx=%0d want %h/0/0", dout16, held16, idx16, exp_b);
        end
        cnt16 = 16'h0778; exp_q16.push_back(8'h78);
        tick;
        cnt16 = 16'h9999; exp_q16.push_back(8'h07);
        exp_b = exp_q16.pop_front();
        n_cmp++; if (dout16 !== exp_b || held16 !== 1'b1 || idx16 !== 1'b1) begin
            n_err++; $display("FAIL load_next: dout=%h held=%b idx=%0d want %h/1/1", dout16, held16, idx16, exp_b);
        end
        tick;
        rd16 = 1'b0;
        exp_b = exp_q16.pop_front();
        n_cmp++; if (dout16 !== exp_b || held16 !== 1'b0) begin
            n_err++; $display("FAIL load_snap: dout=%h held=%b want %h/0", dout16, held16, exp_b);
        end
        n_cmp++; if (exp_q16.size() != 0 || exp_q32.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: left16=%0d left32=%0d want 0/0", exp_q16.size(), exp_q32.size());
        end
    endtask

    initial begin
        test_reset;
        test_auto_latch;
        test_latch32;
        test_latch_while_held;
        test_back_to_back;
        test_ctr_load;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
